uart_tx_arbiter: RTL and testbench

- Shares the single UART byte sender (8-bit data, enable strobe, idle status) between N on-chip requesters, e.g. the CPU MMIO path and a hardware debug/trace source.
- Selects requesters round-robin and drives the sender's data and enable inputs.
- Holds the enable strobe until the sender, which runs on the slower baud clock, acknowledges the byte.
- Acknowledges each requester one byte at a time, with a watchdog for a stuck sender.

---
 rtl/uart_tx_arbiter.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART byte sender between N requesters.
// It holds tx_en until the sender (baud domain) reports busy, then acks the owner.
// A watchdog aborts a byte the sender never accepts; err is sticky until reset.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | wait for a request and a synchronized-idle sender, pick winner
// S_GRANT | byte and owner latched, raise tx_en, clear watchdog
// S_START | tx_en held, wait for sender to go busy or watchdog expiry
// S_DRAIN | byte accepted and acked, wait for sender to return idle
module uart_tx_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [N-1:0]   i_req,
  input  logic [8*N-1:0] i_req_data,
  output logic [N-1:0]   o_ack,
  output logic [7:0]     o_tx_data,
  output logic           o_tx_en,
  input  logic           i_tx_status,
  output logic           o_busy,
  output logic [2:0]     o_owner,
  output logic           o_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_START, S_DRAIN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_sts_meta;
  logic          r_sts_s;
  logic [2:0]    r_ptr;
  logic [2:0]    r_owner;
  logic [7:0]    r_tx_data;
  logic          r_tx_en;
  logic [N-1:0]  r_ack;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic          w_found;
  logic [2:0]    w_win;
  logic [7:0]    w_win_data;
  logic [2:0]    w_ptr_nxt;
  logic [3:0]    w_scan;
  logic [N-1:0]  w_owner_oh;
  logic          w_load;
  logic          w_en_set;
  logic          w_accept;
  logic          w_timeout;
  logic          w_cnt_inc;

  // Two-flop synchronizer: the sender's idle flag lives in the baud domain.
  // Resets to "busy" so nothing is granted until idle has really been seen.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sts_meta <= 1'b0;
      r_sts_s    <= 1'b0;
    end else begin
      r_sts_meta <= i_tx_status;
      r_sts_s    <= r_sts_meta;
    end
  end

  // Round-robin scan starting at the pointer; first asserted request wins.
  always_comb begin
    w_found    = 1'b0;
    w_win      = r_ptr;
    w_scan     = '0;
    w_win_data = '0;
    for (int i = 0; i < N; i++) begin
      w_scan = {1'b0, r_ptr} + 4'(i);
      if (w_scan >= 4'(N)) w_scan = w_scan - 4'(N);
      for (int j = 0; j < N; j++) begin
        if (!w_found && (w_scan == 4'(j)) && i_req[j]) begin
          w_found = 1'b1;
          w_win   = 3'(j);
        end
      end
    end
    for (int j = 0; j < N; j++) begin
      if (w_win == 3'(j)) w_win_data = i_req_data[8*j +: 8];
    end
    w_ptr_nxt = (w_win == 3'(N - 1)) ? 3'd0 : w_win + 3'd1;
    for (int j = 0; j < N; j++) begin
      w_owner_oh[j] = (r_owner == 3'(j));
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and datapath strobes.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_en_set  = 1'b0;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    w_cnt_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found && r_sts_s) begin
          w_load = 1'b1;
          w_next = S_GRANT;
        end
      end
      S_GRANT: begin
        w_en_set = 1'b1;
        w_next   = S_START;
      end
      S_START: begin
        if (!r_sts_s) begin
          w_accept = 1'b1;
          w_next   = S_DRAIN;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_sts_s) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Registered outputs: owner/byte latch, strobe, ack pulse, watchdog, error.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ptr     <= '0;
      r_owner   <= '0;
      r_tx_data <= '0;
      r_tx_en   <= 1'b0;
      r_ack     <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_ack <= '0;
      if (w_load) begin
        r_owner   <= w_win;
        r_tx_data <= w_win_data;
        r_ptr     <= w_ptr_nxt;
      end
      if (w_en_set) begin
        r_tx_en <= 1'b1;
        r_cnt   <= '0;
      end
      if (w_accept) begin
        r_tx_en <= 1'b0;
        r_ack   <= w_owner_oh;
      end
      if (w_timeout) begin
        r_tx_en <= 1'b0;
        r_err   <= 1'b1;
      end
      if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_ack     = r_ack;
  assign o_tx_data = r_tx_data;
  assign o_tx_en   = r_tx_en;
  assign o_busy    = (r_state != S_IDLE);
  assign o_owner   = r_owner;
  assign o_err     = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: N=4, short watchdog, behavioural UART sender,
// level requesters and an expected-grant scoreboard checked on every ack.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  ack;
  logic [7:0]    tx_data;
  logic          tx_en;
  logic          tx_status;
  logic          busy;
  logic [2:0]    owner;
  logic          err;

  uart_tx_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_req       (req),
    .i_req_data  (req_data),
    .o_ack       (ack),
    .o_tx_data   (tx_data),
    .o_tx_en     (tx_en),
    .i_tx_status (tx_status),
    .o_busy      (busy),
    .o_owner     (owner),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requesters: req[i] stays high while issued bytes are not yet acked.
  int         issued [N];
  int         acked  [N];
  logic [7:0] dat    [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req[i]              = (issued[i] != acked[i]);
      req_data[8*i +: 8]  = dat[i];
    end
  end

  // Sender model: goes busy 3 clk after seeing tx_en, shifts for 8 clk.
  logic sender_ok  = 1'b1;
  logic force_busy = 1'b0;
  logic sm_status  = 1'b1;
  int   sm_state   = 0;
  int   sm_cnt     = 0;

  assign tx_status = force_busy ? 1'b0 : sm_status;

  always @(posedge clk) begin
    case (sm_state)
      0: if (tx_en && sender_ok && !force_busy) begin
           sm_cnt   <= 1;
           sm_state <= 1;
         end
      1: if (sm_cnt == 3) begin
           sm_status <= 1'b0;
           sm_cnt    <= 0;
           sm_state  <= 2;
         end else sm_cnt <= sm_cnt + 1;
      default: if (sm_cnt == 8) begin
           sm_status <= 1'b1;
           sm_state  <= 0;
         end else sm_cnt <= sm_cnt + 1;
    endcase
  end

  // Scoreboard of expected grants in order.
  typedef struct { int own; logic [7:0] data; } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input int o, input logic [7:0] d);
    exp_t e;
    e.own  = o;
    e.data = d;
    exp_q.push_back(e);
  endtask

  logic [N-1:0] prev_ack = '0;

  // Ack monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (ack != '0) begin
      int   idx;
      exp_t e;
      idx = 0;
      for (int i = 0; i < N; i++) if (ack[i]) idx = i;
      chk("ack_onehot", $countones(ack), 1);
      chk("ack_one_cycle", prev_ack, 0);
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", ack, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_index", idx, e.own);
        chk("owner_at_ack", owner, e.own);
        chk("tx_data_at_ack", tx_data, e.data);
      end
      acked[idx] = acked[idx] + 1;
    end
    prev_ack = ack;
  end

  task automatic wait_idle();
    int  cyc;
    bit  done;
    cyc  = 0;
    done = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      done = (exp_q.size() == 0) && !busy && (sm_state == 0) && sm_status;
      for (int i = 0; i < N; i++) if (issued[i] != acked[i]) done = 0;
    end
    if (!done) chk("wait_idle_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < N; i++) begin
      issued[i] = 0;
      acked[i]  = 0;
      dat[i]    = 8'h00;
    end

    // Reset values
    #1;
    chk("rst_tx_en", tx_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_err", err, 0);
    chk("rst_ack", ack, 0);
    chk("rst_tx_data", tx_data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single request: latency and data
    dat[0] = 8'h55;
    push_exp(0, 8'h55);
    issued[0]++;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!tx_en && cnt < 50);
    chk("req_to_tx_en", cnt, 2);
    chk("tx_data_single", tx_data, 8'h55);
    wait_idle();
    chk("busy_after_single", busy, 0);

    // Two requesters held: strict alternation
    do_reset();
    dat[0] = 8'hA0;
    dat[1] = 8'hB1;
    push_exp(0, 8'hA0);
    push_exp(1, 8'hB1);
    push_exp(0, 8'hA0);
    push_exp(1, 8'hB1);
    issued[0] += 2;
    issued[1] += 2;
    wait_idle();

    // Pointer wrap 3 -> 0
    do_reset();
    dat[2] = 8'h02;
    push_exp(2, 8'h02);
    issued[2]++;
    wait_idle();
    dat[3] = 8'h03;
    dat[0] = 8'h10;
    push_exp(3, 8'h03);
    push_exp(0, 8'h10);
    issued[3]++;
    issued[0]++;
    wait_idle();

    // Watchdog: sender never accepts
    sender_ok = 1'b0;
    dat[1] = 8'h77;
    issued[1]++;
    cnt = 0;
    while (!tx_en && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    while (tx_en && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("timeout_tx_en_cycles", cnt, TO);
    chk("timeout_err", err, 1);
    sender_ok = 1'b1;
    push_exp(1, 8'h77);
    wait_idle();
    chk("err_sticky", err, 1);

    // Reset during DRAIN
    dat[2] = 8'h62;
    push_exp(2, 8'h62);
    issued[2]++;
    cnt = 0;
    while (!ack[2] && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("drain_reached", ack[2], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_en", tx_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_owner", owner, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dat[1] = 8'h91;
    dat[3] = 8'h93;
    push_exp(1, 8'h91);
    push_exp(3, 8'h93);
    issued[1]++;
    issued[3]++;
    wait_idle();

    // Sender busy: no grant until synchronized idle
    force_busy = 1'b1;
    repeat (4) @(negedge clk);
    dat[0] = 8'h4C;
    push_exp(0, 8'h4C);
    issued[0]++;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_en || busy) cnt++;
    end
    chk("no_grant_while_busy", cnt, 0);
    force_busy = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!busy && cnt < 50);
    chk("status_to_grant", cnt, 3);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
